rr_mux_sched: RTL
=================

// Module: rr_mux_sched
//
// PURPOSE
//  Round-robin scheduler that shares one 8:1 bit-select datapath among 8
//  requesters. It arbitrates req[7:0], drives the 3-bit select of an internal
//  mux8_1 instance, and holds each grant for a bounded burst. It sits between
//  8 single-bit producer lanes and a single serial consumer.
//
// PARAMETERS
//  MAX_BEATS   4   max consecutive beats per grant (legal range 1..8)
//  CNT_W       3   localparam, width of the beat counter, = clog2(8)
//
// PORTS
//  clk        in   1  rising-edge clock; the only clock
//  rst        in   1  synchronous, active-high reset
//  req        in   8  req[i]=1: lane i has a bit to send this cycle
//  din        in   8  din[i] is lane i's data bit, valid while req[i]=1
//  grant      out  8  one-hot current owner; all zero when idle
//  sel        out  3  select driven into mux8_1; equals index of the grant
//  out_valid  out  1  a beat is transferred this cycle
//  out_bit    out  1  transferred data bit (mux8_1 output)
//  busy       out  1  1 in BUSY state
//
// BEHAVIOUR
//  - Reset values (rst=1 at an edge): state=IDLE, grant=0, sel=0, busy=0,
//    cnt=0, last=7. With last=7, lane 0 has top priority after reset.
//  - rst has priority over every other event, including a burst in progress.
//    After reset the design returns to IDLE with no beat emitted.
//  - States: IDLE, BUSY. All of grant, sel, busy, cnt and last are registered.
//  - IDLE, req==0: stay in IDLE; all outputs hold their idle values.
//  - IDLE, req!=0: the winner is the first set bit scanning last+1, last+2, ...
//    (mod 8). At the edge, state=BUSY, sel=winner, grant=1<<winner, cnt=0.
//    Latency: req sampled at edge N, grant visible after edge N.
//  - BUSY: out_valid = req[sel] & busy, combinational. out_bit = din[sel] via
//    mux8_1, also combinational. grant and sel are stable for the whole burst.
//  - BUSY release condition: req[sel]==0, or (req[sel]==1 && cnt==MAX_BEATS-1).
//    - On release at an edge: state=IDLE, grant=0, last=sel, cnt=0.
//      The sel register holds its value.
//    - Otherwise: cnt=cnt+1.
//  - Each grant therefore yields 0..MAX_BEATS beats. If req[sel] is already 0
//    in the first BUSY cycle, the grant yields 0 beats and still updates last.
//  - Every grant is followed by exactly one IDLE cycle (arbitration bubble).
//    No back-to-back grants.
//  - Requests from other lanes during BUSY are ignored until the next IDLE cycle.
//  - A lane that drops req mid-burst and re-raises it competes normally
//    in round-robin order.
//  - Counter width: cnt never exceeds MAX_BEATS-1, so it never wraps.
//  - Fairness: with all 8 lanes requesting continuously, grants go to
//    0,1,...,7,0,... Each grant is MAX_BEATS beats plus 1 bubble.
//
// STRUCTURE
//  - Package rr_mux_pkg holds the state enum (IDLE=1'b0, BUSY=1'b1),
//    N_LANES=8 and SEL_W=3.
//  - Sub-module: existing mux8_1 (in=din, sel=sel, out=out_bit),
//    instantiated once.
//  - The round-robin winner search is a combinational function in this module.
//    No further sub-modules.
//
// TESTING
//  1. Reset: hold rst for 2 cycles with req=8'hFF. Then grant=0, busy=0,
//     sel=0, out_valid=0. First grant after release is 8'h01.
//  2. Single lane: req=8'h08 held for 10 cycles, din[3] toggling. Expect:
//     - sel=3 and 4 beats with out_bit==din[3];
//     - then 1 IDLE cycle;
//     - then re-grant to lane 3.
//  3. Round robin: req=8'hFF held. Grant order is 01,02,04,...,80,01.
//     Each grant lasts 4 BUSY cycles and is separated by 1 IDLE cycle.
//  4. Early release: lane 5 granted, req[5] dropped after 2 beats.
//     Expect 2 beats, then IDLE, last=5. Next winner with req=8'h21 is lane 0.
//  5. Mid-burst reset: rst=1 during beat 2 of a lane 6 grant. Next cycle:
//     grant=0, out_valid=0. The next grant with req=8'h40 is lane 6.
//  6. Zero-beat grant: req=8'h04 for exactly 1 cycle in IDLE. Expect a single
//     BUSY cycle with out_valid=0, then IDLE with last=2.

Source files
------------

// File: rtl/rr_mux_pkg.sv
// Shared types and sizes for the round-robin 8:1 bit-select scheduler.
package rr_mux_pkg;

  localparam int N_LANES = 8;
  localparam int SEL_W   = 3;

  typedef enum logic [0:0] {
    IDLE = 1'b0,
    BUSY = 1'b1
  } state_e;

endpackage

// File: rtl/mux8_1.sv
// Single-bit 8:1 multiplexer shared by the producer lanes.
module mux8_1 (
  input  logic [7:0] in,
  input  logic [2:0] sel,
  output logic       out
);

  assign out = in[sel];

endmodule

// File: rtl/rr_mux_sched.sv
// Round-robin scheduler: grants one of 8 lanes the shared bit-select datapath
// for a burst of up to MAX_BEATS beats, with one arbitration bubble between grants.
//
// state | meaning
// IDLE  | no owner; arbitrate req starting after the last served lane
// BUSY  | grant/sel held; beats flow while req[sel] is set, up to MAX_BEATS
module rr_mux_sched
  import rr_mux_pkg::*;
#(
  parameter int MAX_BEATS = 4
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [7:0]   req,
  input  logic [7:0]   din,
  output logic [7:0]   grant,
  output logic [2:0]   sel,
  output logic         out_valid,
  output logic         out_bit,
  output logic         busy
);

  localparam int CNT_W = 3;
  localparam logic [CNT_W-1:0] LAST_BEAT = CNT_W'(MAX_BEATS - 1);
  localparam logic [0:0] S_IDLE = 1'(IDLE);
  localparam logic [0:0] S_BUSY = 1'(BUSY);

  logic [0:0]       state;
  logic [CNT_W-1:0] cnt;
  logic [SEL_W-1:0] last;
  logic [SEL_W-1:0] winner;
  logic             release_burst;

  // First requesting lane after 'l', wrapping mod 8; 'l' itself is checked last.
  function automatic logic [SEL_W-1:0] rr_pick(input logic [N_LANES-1:0] r,
                                               input logic [SEL_W-1:0]   l);
    logic [SEL_W-1:0] idx;
    logic             found;
    rr_pick = '0;
    found   = 1'b0;
    for (int i = 1; i <= N_LANES; i++) begin
      idx = l + SEL_W'(i);
      if (!found && r[idx]) begin
        rr_pick = idx;
        found   = 1'b1;
      end
    end
  endfunction

  assign winner        = rr_pick(req, last);
  assign busy          = (state == S_BUSY);
  assign out_valid     = req[sel] & busy;
  assign release_burst = !req[sel] || (cnt == LAST_BEAT);

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= S_IDLE;
      grant <= '0;
      sel   <= '0;
      cnt   <= '0;
      last  <= 3'd7;
    end else if (state == S_IDLE) begin
      if (|req) begin
        state <= S_BUSY;
        sel   <= winner;
        grant <= 8'(1) << winner;
        cnt   <= '0;
      end
    end else begin
      // sel deliberately holds through the bubble; only grant clears.
      if (release_burst) begin
        state <= S_IDLE;
        grant <= '0;
        last  <= sel;
        cnt   <= '0;
      end else begin
        cnt <= cnt + CNT_W'(1);
      end
    end
  end

  mux8_1 u_mux (
    .in  (din),
    .sel (sel),
    .out (out_bit)
  );

endmodule
